rgmii_rx_parser: RTL and testbench

- Receive-side frame parser directly downstream of the clock/reset block and the RGMII input DDR capture registers.
- Runs on the 125 MHz fabric RX clock (clk125RxOut of the clock block).
- Consumes rising- and falling-edge nibble pairs, strips the preamble and SFD, and streams frame bytes with start/end markers.
- Checks FCS, length and RX_ER, and keeps good/bad frame counters for the MAC/book-builder logic.

---
 rtl/rgmii_rx_parser.sv | 248 ++++++++++++++++++++++++
 tb/tb_rgmii_rx_parser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_parser.sv
// RGMII receive parser: decodes DDR nibble pairs, strips preamble/SFD, streams frame
// bytes with sof/eof markers, checks FCS/length/RX_ER and counts good and bad frames.
module rgmii_rx_parser #(
  parameter int MIN_PREAMBLE  = 2,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int CNT_W         = 16
) (
  input  logic             clkIn,
  input  logic             rstBIn,
  input  logic [3:0]       rxDataRiseIn,
  input  logic [3:0]       rxDataFallIn,
  input  logic             rxCtrlRiseIn,
  input  logic             rxCtrlFallIn,
  output logic [7:0]       dataOut,
  output logic             validOut,
  output logic             sofOut,
  output logic             eofOut,
  output logic             errOut,
  output logic [CNT_W-1:0] goodFrameCntOut,
  output logic [CNT_W-1:0] badFrameCntOut,
  output logic [1:0]       dbgStateOut
);

  localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_FRAME_LEN);
  localparam logic [2:0]       MIN_PRE_C = 3'(MIN_PREAMBLE);
  localparam logic [31:0]      RESIDUE   = 32'hC704DD7B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // One reflected CRC-32 step per byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The shift register holds the residue bit-reversed relative to its usual form.
  function automatic logic [31:0] rev32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = c[31-i];
    end
    return r;
  endfunction

  // Stage 1: registered decode of the DDR pair.
  logic [7:0] s1_byte_q;
  logic       s1_dv_q;
  logic       s1_er_q;

  // Stage 2: parser state and held byte.
  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [2:0]       pre_q, pre_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             errf_q, errf_d;
  logic [7:0]       hold_q, hold_d;
  logic             hvld_q, hvld_d;
  logic             hsof_q, hsof_d;

  // Output stage: validOut qualifies dataOut/sofOut/eofOut for exactly one cycle;
  // there is no ready, the consumer must accept every valid byte.
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic [31:0] crc_next;
  assign crc_next = crc_byte(crc_q, s1_byte_q);

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      s1_byte_q <= 8'h00;
      s1_dv_q   <= 1'b0;
      s1_er_q   <= 1'b0;
    end else begin
      s1_byte_q <= {rxDataFallIn, rxDataRiseIn};
      s1_dv_q   <= rxCtrlRiseIn;
      s1_er_q   <= rxCtrlRiseIn ^ rxCtrlFallIn;
    end
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      pre_q       <= 3'd0;
      crc_q       <= 32'hFFFFFFFF;
      len_q       <= '0;
      errf_q      <= 1'b0;
      hold_q      <= 8'h00;
      hvld_q      <= 1'b0;
      hsof_q      <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      pre_q       <= pre_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      errf_q      <= errf_d;
      hold_q      <= hold_d;
      hvld_q      <= hvld_d;
      hsof_q      <= hsof_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // Armed from the raw pin so the reset value of stage 1 cannot arm a frame in progress.
    armed_d     = armed_q | ~rxCtrlRiseIn;
    pre_d       = pre_q;
    crc_d       = crc_q;
    len_d       = len_q;
    errf_d      = errf_q;
    hold_d      = hold_q;
    hvld_d      = hvld_q;
    hsof_d      = hsof_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;

    case (state_q)
      ST_IDLE: begin
        if (s1_dv_q) begin
          if (armed_q && s1_byte_q == 8'h55) begin
            state_d = ST_PRE;
            pre_d   = 3'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!s1_dv_q) begin
          state_d = ST_IDLE;
        end else if (s1_er_q) begin
          state_d = ST_DROP;
        end else if (s1_byte_q == 8'h55) begin
          if (pre_q != 3'd7) pre_d = pre_q + 3'd1;
        end else if (s1_byte_q == 8'hD5 && pre_q >= MIN_PRE_C) begin
          state_d = ST_DATA;
          crc_d   = 32'hFFFFFFFF;
          len_d   = '0;
          errf_d  = 1'b0;
          hvld_d  = 1'b0;
          hsof_d  = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (s1_dv_q) begin
          if (len_q == MAX_LEN_C) begin
            // Frame overruns: close it on the held byte and discard the rest.
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = hsof_q;
            out_eof_d   = 1'b1;
            out_err_d   = 1'b1;
            hvld_d      = 1'b0;
            state_d     = ST_DROP;
          end else begin
            crc_d  = crc_next;
            len_d  = len_q + LEN_W'(1);
            errf_d = errf_q | s1_er_q;
            if (hvld_q) begin
              out_valid_d = 1'b1;
              out_data_d  = hold_q;
              out_sof_d   = hsof_q;
            end
            hold_d = s1_byte_q;
            hvld_d = 1'b1;
            hsof_d = (len_q == '0);
          end
        end else begin
          if (hvld_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = hsof_q;
            out_eof_d   = 1'b1;
            out_err_d   = errf_q | (rev32(crc_q) != RESIDUE) | (len_q < MIN_LEN_C);
          end
          hvld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!s1_dv_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (out_eof_d) begin
      if (out_err_d) begin
        if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
      end else begin
        if (good_q != '1) good_d = good_q + CNT_W'(1);
      end
    end
  end

  assign dataOut         = out_data_q;
  assign validOut        = out_valid_q;
  assign sofOut          = out_sof_q;
  assign eofOut          = out_eof_q;
  assign errOut          = out_err_q;
  assign goodFrameCntOut = good_q;
  assign badFrameCntOut  = bad_q;
  assign dbgStateOut     = state_q;

endmodule

// File: tb/tb_rgmii_rx_parser.sv
// Bench for rgmii_rx_parser: table of frame scenarios, random frames against a
// frame-level model, and a mid-frame reset sequence.
module tb_rgmii_rx_parser;

  localparam int MIN_PRE = 2;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;
  localparam int CNT_W   = 16;

  logic             clkIn = 1'b0;
  logic             rstBIn = 1'b0;
  logic [3:0]       rxDataRiseIn = 4'h0;
  logic [3:0]       rxDataFallIn = 4'h0;
  logic             rxCtrlRiseIn = 1'b0;
  logic             rxCtrlFallIn = 1'b0;
  logic [7:0]       dataOut;
  logic             validOut, sofOut, eofOut, errOut;
  logic [CNT_W-1:0] goodFrameCntOut, badFrameCntOut;
  logic [1:0]       dbgStateOut;

  rgmii_rx_parser #(
    .MIN_PREAMBLE(MIN_PRE), .MIN_FRAME_LEN(MIN_LEN),
    .MAX_FRAME_LEN(MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .clkIn(clkIn), .rstBIn(rstBIn),
    .rxDataRiseIn(rxDataRiseIn), .rxDataFallIn(rxDataFallIn),
    .rxCtrlRiseIn(rxCtrlRiseIn), .rxCtrlFallIn(rxCtrlFallIn),
    .dataOut(dataOut), .validOut(validOut), .sofOut(sofOut), .eofOut(eofOut),
    .errOut(errOut), .goodFrameCntOut(goodFrameCntOut),
    .badFrameCntOut(badFrameCntOut), .dbgStateOut(dbgStateOut)
  );

  // clock / reset
  always #4 clkIn = ~clkIn;
  int unsigned cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  initial begin
    #(80000 * 8);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {edge, err, eof, sof, data}
  logic [42:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 0;
  bit armed_m = 0;
  int good_m = 0;
  int bad_m = 0;
  logic [7:0] fr[$];

  always @(negedge clkIn) begin : monitor
    logic [42:0] act;
    logic [42:0] e;
    if (mon_en) begin
      if (validOut) begin
        act = {cyc, errOut & eofOut, eofOut, sofOut, dataOut};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %h, required no output", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL out_byte: got %h, required %h", act, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0][42:11] < cyc) begin
        n_cmp++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL out_missing: got none at %0d, required %h", cyc, e);
      end
    end
  end

  // model helpers
  function automatic logic [31:0] crc32_fr(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit model_err(input int n, input int er_idx);
    bit e;
    logic [31:0] got;
    if (n > MAX_LEN) return 1'b1;
    e = (er_idx >= 0 && er_idx < n);
    if (n < MIN_LEN) begin
      e = 1'b1;
    end else begin
      got = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
      if (got != crc32_fr(n - 4)) e = 1'b1;
    end
    return e;
  endfunction

  task automatic build_frame(input int plen, input int mode);
    logic [31:0] c;
    int idx;
    fr.delete();
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom_range(0, 255)));
    if (mode != 2) begin
      c = crc32_fr(plen);
      fr.push_back(c[7:0]);
      fr.push_back(c[15:8]);
      fr.push_back(c[23:16]);
      fr.push_back(c[31:24]);
    end
    if (mode == 1 && plen > 0) begin
      idx = $urandom_range(0, plen - 1);
      fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
    end
  endtask

  // driver
  task automatic drive(input logic [7:0] b, input logic dv, input logic er,
                       output int unsigned s);
    @(negedge clkIn);
    rxDataRiseIn = b[3:0];
    rxDataFallIn = b[7:4];
    rxCtrlRiseIn = dv;
    rxCtrlFallIn = dv ^ er;
    s = cyc + 1;
    if (!dv && rstBIn) armed_m = 1'b1;
  endtask

  task automatic send_frame(input int npre, input bit sfd, input int er_idx, input int gap);
    int unsigned s;
    int n, m;
    bit take, ferr;
    n = fr.size();
    take = armed_m && sfd && (npre >= MIN_PRE) && (n > 0);
    m = (n > MAX_LEN) ? MAX_LEN : n;
    ferr = model_err(n, er_idx);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0, s);
    if (sfd) drive(8'hD5, 1'b1, 1'b0, s);
    for (int k = 0; k < n; k++) begin
      drive(fr[k], 1'b1, 1'(k == er_idx), s);
      if (take && k < m)
        exp_q.push_back({s + 2, 1'((k == m - 1) ? ferr : 1'b0), 1'(k == m - 1), 1'(k == 0), fr[k]});
    end
    if (take) begin
      if (ferr) bad_m++;
      else good_m++;
    end
    for (int g = 0; g < gap; g++) drive(8'($urandom_range(0, 255)), 1'b0, 1'b0, s);
    if (gap >= 3) begin
      n_cmp++;
      if ({goodFrameCntOut, badFrameCntOut} !== {CNT_W'(good_m), CNT_W'(bad_m)}) begin
        n_fail++;
        $display("FAIL cnt_model: got good=%0d bad=%0d, required good=%0d bad=%0d",
                 goodFrameCntOut, badFrameCntOut, good_m, bad_m);
      end
    end
  endtask

  typedef struct {
    int npre; bit sfd; int plen; int mode; int er_idx; int gap;
    bit chk; int dgood; int dbad;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int unsigned s;
    int tally_g, tally_b;
    int npre, plen, mode, er_idx, gap;
    bit sfd;

    // npre, sfd, plen, mode(0 good FCS,1 bit flip,2 no FCS), er_idx, gap, chk, dgood, dbad
    tbl[0]  = '{7, 1'b1, 60,   0, -1, 4, 1'b1, 1, 0};
    tbl[1]  = '{7, 1'b1, 60,   1, -1, 4, 1'b1, 0, 1};
    tbl[2]  = '{7, 1'b1, 60,   0, 19, 4, 1'b1, 0, 1};
    tbl[3]  = '{7, 1'b1, 1596, 0, -1, 4, 1'b1, 0, 1};
    tbl[4]  = '{7, 1'b1, 60,   0, -1, 4, 1'b1, 1, 0};
    tbl[5]  = '{7, 1'b1, 26,   0, -1, 4, 1'b1, 0, 1};
    tbl[6]  = '{1, 1'b1, 0,    2, -1, 4, 1'b1, 0, 0};
    tbl[7]  = '{2, 1'b1, 60,   0, -1, 4, 1'b1, 1, 0};
    tbl[8]  = '{3, 1'b0, 10,   2, -1, 4, 1'b1, 0, 0};
    tbl[9]  = '{7, 1'b1, 1,    2, -1, 4, 1'b1, 0, 1};
    tbl[10] = '{7, 1'b1, 1518, 0, -1, 4, 1'b1, 1, 0};
    tbl[11] = '{12, 1'b1, 60,  0, -1, 4, 1'b1, 1, 0};
    tbl[12] = '{7, 1'b1, 100,  0, -1, 1, 1'b0, 1, 0};
    tbl[13] = '{7, 1'b1, 60,   0, -1, 4, 1'b1, 1, 0};

    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({dataOut, validOut, sofOut, eofOut, errOut, goodFrameCntOut, badFrameCntOut, dbgStateOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h v=%b sof=%b eof=%b err=%b good=%0d bad=%0d st=%0d, required all 0",
               dataOut, validOut, sofOut, eofOut, errOut, goodFrameCntOut, badFrameCntOut, dbgStateOut);
    end
    rstBIn = 1'b1;
    mon_en = 1'b1;
    repeat (3) drive(8'h00, 1'b0, 1'b0, s);

    tally_g = 0;
    tally_b = 0;
    foreach (tbl[i]) begin
      build_frame(tbl[i].plen, tbl[i].mode);
      if (!tbl[i].sfd && fr.size() > 0) fr[0] = 8'h12;
      send_frame(tbl[i].npre, tbl[i].sfd, tbl[i].er_idx, tbl[i].gap);
      tally_g += tbl[i].dgood;
      tally_b += tbl[i].dbad;
      if (tbl[i].chk) begin
        n_cmp++;
        if ({goodFrameCntOut, badFrameCntOut} !== {CNT_W'(tally_g), CNT_W'(tally_b)}) begin
          n_fail++;
          $display("FAIL cnt_vec%0d: got good=%0d bad=%0d, required good=%0d bad=%0d",
                   i, goodFrameCntOut, badFrameCntOut, tally_g, tally_b);
        end
      end
    end

    for (int r = 0; r < 40; r++) begin
      npre = $urandom_range(0, 9);
      sfd  = ($urandom_range(0, 9) != 0);
      plen = ($urandom_range(0, 19) == 0) ? $urandom_range(1515, 1530) : $urandom_range(0, 120);
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      er_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, plen + 3) : -1;
      gap = $urandom_range(1, 4);
      build_frame(plen, mode);
      if (!sfd && fr.size() > 0) fr[0] = 8'h12;
      send_frame(npre, sfd, er_idx, gap);
    end
    repeat (4) drive(8'h00, 1'b0, 1'b0, s);

    // reset mid-payload, released while dv is still high
    mon_en = 1'b0;
    build_frame(60, 0);
    repeat (7) drive(8'h55, 1'b1, 1'b0, s);
    drive(8'hD5, 1'b1, 1'b0, s);
    for (int k = 0; k < 20; k++) drive(fr[k], 1'b1, 1'b0, s);
    rstBIn = 1'b0;
    #1;
    n_cmp++;
    if ({dataOut, validOut, sofOut, eofOut, errOut, goodFrameCntOut, badFrameCntOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%h v=%b sof=%b eof=%b err=%b good=%0d bad=%0d, required all 0",
               dataOut, validOut, sofOut, eofOut, errOut, goodFrameCntOut, badFrameCntOut);
    end
    for (int k = 20; k < 30; k++) drive(fr[k], 1'b1, 1'b0, s);
    rstBIn = 1'b1;
    armed_m = 1'b0;
    good_m = 0;
    bad_m = 0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int k = 30; k < fr.size(); k++) drive(fr[k], 1'b1, 1'b0, s);
    repeat (4) drive(8'h00, 1'b0, 1'b0, s);
    n_cmp++;
    if ({goodFrameCntOut, badFrameCntOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_ignored: got good=%0d bad=%0d, required 0 0",
               goodFrameCntOut, badFrameCntOut);
    end
    build_frame(60, 0);
    send_frame(7, 1'b1, -1, 4);
    n_cmp++;
    if ({goodFrameCntOut, badFrameCntOut} !== {CNT_W'(1), CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL reset_next_frame: got good=%0d bad=%0d, required 1 0",
               goodFrameCntOut, badFrameCntOut);
    end

    repeat (5) drive(8'h00, 1'b0, 1'b0, s);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
